// File: rtl/dds_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : dds_freq_meter
// Brief    : Period meter for offset-binary sine samples using a hysteresis
//            comparator and an NCYC-cycle gate. Define DDS_FMETER_FWORD_EN to
//            add a serial divider that turns the period into a frequency word.
// Revision : 1.0 - initial release
// ============================================================================
module dds_freq_meter #(
    parameter int DW      = 8,
    parameter int MID     = 128,
    parameter int HYST    = 8,
    parameter int NCYC    = 16,
    parameter int CW      = 32,
    parameter int TIMEOUT = 1000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample,
    output logic [CW-1:0] meas_period,
    output logic          meas_valid,
    output logic          locked,
    output logic          timeout,
    output logic [31:0]   fword,
    output logic          fword_valid
);

    localparam int c_edge_w = $clog2(NCYC + 1);

    localparam logic [1:0] c_cmp_init = 2'd0;
    localparam logic [1:0] c_cmp_lo   = 2'd1;
    localparam logic [1:0] c_cmp_hi   = 2'd2;

    localparam logic c_st_idle = 1'b0;
    localparam logic c_st_meas = 1'b1;

    localparam logic [DW:0]       c_mid      = (DW+1)'(MID);
    localparam logic [DW:0]       c_hyst     = (DW+1)'(HYST);
    localparam logic [DW:0]       c_hi_th    = (DW+1)'(MID + HYST);
    localparam logic [CW-1:0]     c_to_last  = CW'(TIMEOUT - 1);
    localparam logic [c_edge_w-1:0] c_ncyc   = c_edge_w'(NCYC);

    logic [1:0]          r_cmp;
    logic                r_state;
    logic                w_state_next;
    logic [CW-1:0]       r_cyc_cnt;
    logic [c_edge_w-1:0] r_edge_cnt;
    logic [CW-1:0]       r_meas_period;
    logic                r_meas_valid;
    logic                r_locked;
    logic                r_timeout;

    logic [DW:0] w_samp_x;
    logic        w_hi_hit;
    logic        w_lo_hit;
    logic        w_rise;
    logic        w_gate_done;
    logic        w_to_hit;

    // Thresholds evaluated one bit wider so MID+HYST and sample+HYST never wrap.
    assign w_samp_x = {1'b0, sample};
    assign w_hi_hit = (w_samp_x >= c_hi_th);
    assign w_lo_hit = ((w_samp_x + c_hyst) <= c_mid);
    assign w_rise   = sample_valid && (r_cmp == c_cmp_lo) && w_hi_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmp <= c_cmp_init;
        end else if (sample_valid) begin
            case (r_cmp)
                c_cmp_init: r_cmp <= (w_samp_x >= c_mid) ? c_cmp_hi : c_cmp_lo;
                c_cmp_lo:   if (w_hi_hit) r_cmp <= c_cmp_hi;
                c_cmp_hi:   if (w_lo_hit) r_cmp <= c_cmp_lo;
                default:    r_cmp <= c_cmp_init;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_gate_done  = 1'b0;
        w_to_hit     = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_rise) w_state_next = c_st_meas;
            end
            c_st_meas: begin
                w_gate_done = w_rise && ((r_edge_cnt + 1'b1) == c_ncyc);
                // A completing edge on the last allowed clock still counts as a gate.
                w_to_hit    = !w_gate_done && (r_cyc_cnt == c_to_last);
                if (w_to_hit) w_state_next = c_st_idle;
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc_cnt     <= '0;
            r_edge_cnt    <= '0;
            r_meas_period <= '0;
            r_meas_valid  <= 1'b0;
            r_locked      <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_meas_valid <= w_gate_done;
            r_timeout    <= w_to_hit;
            if (w_gate_done) begin
                r_meas_period <= r_cyc_cnt + 1'b1;
                r_locked      <= 1'b1;
            end else if (w_to_hit) begin
                r_locked <= 1'b0;
            end
            if (r_state == c_st_idle || w_gate_done || w_to_hit) begin
                r_cyc_cnt  <= '0;
                r_edge_cnt <= '0;
            end else begin
                r_cyc_cnt <= r_cyc_cnt + 1'b1;
                if (w_rise) r_edge_cnt <= r_edge_cnt + 1'b1;
            end
        end
    end

    assign meas_period = r_meas_period;
    assign meas_valid  = r_meas_valid;
    assign locked      = r_locked;
    assign timeout     = r_timeout;

`ifdef DDS_FMETER_FWORD_EN
    // Restoring divide of NCYC*2^32 by the period; the dividend's low 32 bits
    // are zero so the remainder starts at NCYC and shifts in zeros.
    logic          r_div_busy;
    logic [4:0]    r_div_cnt;
    logic [CW-1:0] r_rem;
    logic [31:0]   r_quo;
    logic          r_sat;
    logic [31:0]   r_fword;
    logic          r_fword_valid;

    logic [CW:0]   w_rem_sh;
    logic          w_ge;
    logic [CW-1:0] w_rem_nx;
    logic [31:0]   w_quo_nx;

    assign w_rem_sh = {r_rem, 1'b0};
    assign w_ge     = (w_rem_sh >= {1'b0, r_meas_period});
    assign w_rem_nx = w_ge ? CW'(w_rem_sh - {1'b0, r_meas_period}) : CW'(w_rem_sh);
    assign w_quo_nx = {r_quo[30:0], w_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_busy    <= 1'b0;
            r_div_cnt     <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_sat         <= 1'b0;
            r_fword       <= '0;
            r_fword_valid <= 1'b0;
        end else begin
            r_fword_valid <= 1'b0;
            if (r_meas_valid) begin
                r_div_busy <= 1'b1;
                r_div_cnt  <= '0;
                r_rem      <= CW'(NCYC);
                r_quo      <= '0;
                // Quotient reaches 2^32 whenever the period is not above NCYC.
                r_sat      <= (r_meas_period <= CW'(NCYC));
            end else if (r_div_busy) begin
                r_rem     <= w_rem_nx;
                r_quo     <= w_quo_nx;
                r_div_cnt <= r_div_cnt + 1'b1;
                if (r_div_cnt == 5'd31) begin
                    r_div_busy    <= 1'b0;
                    r_fword_valid <= 1'b1;
                    r_fword       <= r_sat ? 32'hFFFF_FFFF : w_quo_nx;
                end
            end
        end
    end

    assign fword       = r_fword;
    assign fword_valid = r_fword_valid;
`else
    assign fword       = '0;
    assign fword_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dds_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_freq_meter
// Brief    : Scoreboard bench for dds_freq_meter; a comparator/gate model
//            queues expected pulses as samples are driven.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dds_freq_meter;

    localparam int DW   = 8;
    localparam int CW   = 32;
    localparam int NCYC = 16;
    localparam int TO   = 5000;
    localparam int HI_TH = 136;
    localparam int LO_TH = 120;

    typedef struct {
        int unsigned at_cyc;
        logic [63:0] val;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] sample = 8'd128;
    logic [CW-1:0] meas_period;
    logic          meas_valid;
    logic          locked;
    logic          timeout;
    logic [31:0]   fword;
    logic          fword_valid;

    int unsigned cyc = 0;
    int n_checks = 0;
    int n_pass   = 0;

    exp_t pq[$];
    exp_t tq[$];
    exp_t fq[$];

    int          m_st;
    bit          m_active;
    int          m_cnt;
    int unsigned m_gs;

    dds_freq_meter #(
        .DW(DW), .MID(128), .HYST(8), .NCYC(NCYC), .CW(CW), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sample_valid(sample_valid),
        .sample(sample),
        .meas_period(meas_period),
        .meas_valid(meas_valid),
        .locked(locked),
        .timeout(timeout),
        .fword(fword),
        .fword_valid(fword_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_rise(input int unsigned e);
        exp_t x;
        if (!m_active) begin
            m_active = 1'b1;
            m_gs     = e;
            m_cnt    = 0;
        end else begin
            m_cnt++;
            if (m_cnt == NCYC) begin
                x.at_cyc = e;
                x.val    = 64'(e - m_gs);
                pq.push_back(x);
                m_gs  = e;
                m_cnt = 0;
            end
        end
    endtask

    // Drive one clock of input; e is the posedge index that will sample it.
    task automatic drive(input bit v, input int s);
        int unsigned e;
        exp_t x;
        sample_valid = v;
        sample       = 8'(s);
        e = cyc + 1;
        if (v) begin
            case (m_st)
                0: m_st = (s >= 128) ? 2 : 1;
                1: if (s >= HI_TH) begin m_st = 2; model_rise(e); end
                2: if (s <= LO_TH) m_st = 1;
                default: m_st = 0;
            endcase
        end
        if (m_active && (e - m_gs) == TO) begin
            x.at_cyc = e;
            x.val    = 64'd1;
            tq.push_back(x);
            m_active = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic run_wave(input int hi, input int lo, input int nhalf, input int every, input int nper);
        for (int p = 0; p < nper; p++)
            for (int h = 0; h < 2; h++)
                for (int c = 0; c < nhalf; c++)
                    for (int k = 0; k < every; k++)
                        drive(k == 0, (h == 0) ? hi : lo);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 128);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        sample_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_st = 0; m_active = 1'b0; m_cnt = 0; m_gs = 0;
        pq.delete(); tq.delete(); fq.delete();
        check({tag, "_period"}, 64'(meas_period), 64'd0);
        check({tag, "_flags"}, {meas_valid, locked, timeout, fword_valid}, 64'd0);
        check({tag, "_fword"}, 64'(fword), 64'd0);
    endtask

    task automatic end_check(input string tag);
        check({tag, "_missing_valid"}, 64'(pq.size()), 64'd0);
        check({tag, "_missing_timeout"}, 64'(tq.size()), 64'd0);
        check({tag, "_missing_fword"}, 64'(fq.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        exp_t x;
        exp_t f;
        if (meas_valid && timeout) check("pulse_overlap", 64'd1, 64'd0);
        if (meas_valid) begin
            if (pq.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                x = pq.pop_front();
                check("valid_cycle", 64'(cyc), 64'(x.at_cyc));
                check("valid_period", 64'(meas_period), x.val);
                check("valid_locked", 64'(locked), 64'd1);
`ifdef DDS_FMETER_FWORD_EN
                f.at_cyc = cyc + 33;
                f.val    = (64'(NCYC) << 32) / x.val;
                if (f.val > 64'hFFFF_FFFF) f.val = 64'hFFFF_FFFF;
                fq.push_back(f);
`else
                check("fword_tied", {fword_valid, fword}, 64'd0);
`endif
            end
        end
        if (timeout) begin
            if (tq.size() == 0) begin
                check("unexpected_timeout", 64'd1, 64'd0);
            end else begin
                x = tq.pop_front();
                check("timeout_cycle", 64'(cyc), 64'(x.at_cyc));
                check("timeout_locked", 64'(locked), 64'd0);
            end
        end
        if (fword_valid) begin
            if (fq.size() == 0) begin
                check("unexpected_fword", 64'd1, 64'd0);
            end else begin
                f = fq.pop_front();
                check("fword_cycle", 64'(cyc), 64'(f.at_cyc));
                check("fword_value", 64'(fword), f.val);
            end
        end
    end

    initial begin
        @(negedge clk);

        // Square wave 200/50, 100 clk period: gate of 16 cycles = 1600 clk.
        do_reset("rst1");
        run_wave(200, 50, 50, 1, 50);
        idle(40);
        check("s1_period", 64'(meas_period), 64'd1600);
        check("s1_locked", 64'(locked), 64'd1);
`ifdef DDS_FMETER_FWORD_EN
        check("s1_fword", 64'(fword), 64'd42949672);
`endif
        end_check("s1");

        // Loss of signal after lock.
        for (int i = 0; i < 5200; i++) drive(1'b1, 200);
        check("s3_locked", 64'(locked), 64'd0);
        check("s3_period_kept", 64'(meas_period), 64'd1600);
        end_check("s3");

        // Swing inside hysteresis: no events, no timeout.
        do_reset("rst2");
        run_wave(130, 126, 50, 1, 60);
        check("s2_locked", 64'(locked), 64'd0);
        check("s2_period", 64'(meas_period), 64'd0);
        end_check("s2");

        // Sparse qualifier: one valid sample in four, 200 clk period.
        do_reset("rst4");
        run_wave(200, 50, 25, 4, 20);
        idle(40);
        check("s4_period", 64'(meas_period), 64'd3200);
        end_check("s4");

        // Reset in the middle of a gate, then a fresh full gate.
        do_reset("rst5a");
        run_wave(200, 50, 50, 1, 5);
        do_reset("rst5b");
        run_wave(200, 50, 50, 1, 20);
        idle(40);
        check("s5_period", 64'(meas_period), 64'd1600);
        check("s5_locked", 64'(locked), 64'd1);
        end_check("s5");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dds_freq_meter.md
Name: dds_freq_meter

Overview:
- Receive side of the DDS path: takes 8-bit offset-binary sine samples (midscale 128, same format as the sine ROM output) and measures their period in clk cycles.
- Uses a hysteresis comparator and edge-gated counting over NCYC input cycles.
- Used to close the loop on the DDS output, and to measure external tones (ADC front end) for the detection chain.
- Optional serial divider converts the measured period back into a DDS frequency word.

Parameters:
- DW, 8: sample width.
- MID, 128: comparator midpoint (offset-binary zero).
- HYST, 8: hysteresis half-width in LSBs.
- NCYC, 16: input cycles per measurement gate. Power of two; 1..256.
- CW, 32: cycle-counter and meas_period width.
- TIMEOUT, 1000000: clk cycles without gate completion before loss of lock. Must be < 2^CW.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- sample_valid  in  1  sample qualifier; samples ignored when low
- sample  in  DW  offset-binary sample
- meas_period  out  CW  clk cycles spanned by the last NCYC input cycles
- meas_valid  out  1  one-cycle pulse; meas_period updated
- locked  out  1  at least one gate completed since last reset/timeout
- timeout  out  1  one-cycle pulse on loss of signal
- fword  out  32  frequency word (only with DDS_FMETER_FWORD_EN)
- fword_valid  out  1  one-cycle pulse (only with DDS_FMETER_FWORD_EN)

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: meas_period=0, meas_valid=0, locked=0, timeout=0, fword=0, fword_valid=0. FSM goes to IDLE, comparator goes to INIT, all counters are cleared.
- Reset mid-gate or mid-divide aborts the gate or divide with no output pulse.
- Comparator states: INIT, LO, HI. It advances only on clocks with sample_valid=1.
  - INIT: sample>=MID goes to HI, otherwise LO. No event is generated.
  - LO goes to HI when sample>=MID+HYST. This transition generates a rise event on that clock.
  - HI goes to LO when sample<=MID-HYST.
  - Threshold sums are computed at DW+1 bits; no wrap.
- FSM states:
  - IDLE: cyc_cnt held at 0. On a rise event: go to MEASURE, cyc_cnt<=0, edge_cnt<=0.
  - MEASURE: cyc_cnt increments every clk.
    - On a rise event: edge_cnt increments.
    - When the event makes edge_cnt==NCYC: meas_period<=cyc_cnt+1, meas_valid<=1, locked<=1, cyc_cnt<=0, edge_cnt<=0. Stay in MEASURE; this edge starts the next gate back-to-back with no dead time.
  - Timeout (MEASURE only): when cyc_cnt==TIMEOUT-1 and no gate completes on that clock: timeout<=1, locked<=0, go to IDLE. meas_period keeps its last value.
  - Simultaneous gate completion and timeout: completion wins.
- Latency: all outputs are registered and visible the clock after the completing rise event.
- meas_valid and timeout are single-cycle pulses and are never asserted together.

Optional Feature:
- Macro: DDS_FMETER_FWORD_EN.
- Defined:
  - Adds a serial restoring divider: fword = floor(NCYC*2^32 / meas_period), 1 quotient bit per clk.
  - Starts the clock after meas_valid. fword and fword_valid update 33 clocks after meas_valid.
  - A new meas_valid during a divide restarts the divide with the new period; the old result is discarded.
  - If the quotient would exceed 32 bits, fword saturates to 32'hFFFFFFFF.
- Undefined: fword and fword_valid are tied to 0 and no divider logic is present.

Test Plan:
1. Reset, sample_valid=1, square input: 50 clocks of 200 then 50 of 50, repeated. Expect the first meas_valid 1600 clocks after the first rise, meas_period=1600, locked=1, pulses every 1600 clocks.
2. Same waveform with a 130/126 swing (inside hysteresis). Expect no rise events, meas_valid never asserted. With TIMEOUT=5000 and no rise, the FSM stays IDLE, so no timeout pulse either.
3. Lock as in scenario 1, then hold sample=200 with TIMEOUT=5000. Expect a timeout pulse 5000 clocks after the last gate start, locked=0, meas_period still 1600.
4. sample_valid high 1 clock in 4, 25 valid samples hi / 25 lo per cycle (period 200 clk). Expect meas_period=3200.
5. Assert rst for 1 clock mid-gate. Expect all outputs 0 next clock; a fresh full gate is needed before meas_valid.
6. DDS_FMETER_FWORD_EN, scenario 1 stimulus. Expect fword=42949672 with fword_valid 33 clocks after each meas_valid.
